// File: rtl/io_rr_arbiter.sv
// io_rr_arbiter: round-robin arbiter that funnels IO_COUNT requesters onto a
// single memory port, one transaction in flight at a time.
// Flow: IDLE (arbitrate and latch) -> ISSUE (one mem_en cycle) ->
// WAIT (reads only; counts down the memory latency) -> DONE (ack pulse).

// Per-requester lane: flags a request that sits at or above the rotating
// pointer, so the top level can prefer those before wrapping to index 0.
module io_rr_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             reqBit,
  input  logic [IDX_W-1:0] ptr,
  output logic             hiReq
);

  assign hiReq = reqBit && (IDX_W'(LANE) >= ptr);

endmodule

module io_rr_arbiter #(
  parameter int IO_COUNT  = 4,
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 16,
  parameter int MEM_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IO_COUNT-1:0]           req,
  input  logic [IO_COUNT-1:0]           we_in,
  input  logic [IO_COUNT*ADDR_SIZE-1:0] addr_in,
  input  logic [IO_COUNT*WORD_SIZE-1:0] wdata_in,
  output logic [IO_COUNT-1:0]           gnt,
  output logic [IO_COUNT-1:0]           ack,
  output logic [WORD_SIZE-1:0]          rdata,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_SIZE-1:0]          mem_addr,
  output logic [WORD_SIZE-1:0]          mem_wdata,
  input  logic [WORD_SIZE-1:0]          mem_rdata
);

  localparam int IDX_W = (IO_COUNT > 1) ? $clog2(IO_COUNT) : 1;
  // The counter only ever holds MEM_LAT-1 down to 0.
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } ioReq_t;

  state_t                     state;
  logic [IDX_W-1:0]           ptr;
  logic [IDX_W-1:0]           idx;
  logic [LAT_W-1:0]           latCnt;
  logic                       isWrite;

  ioReq_t [IO_COUNT-1:0]      reqArr;
  logic   [IO_COUNT-1:0]      hiReq;
  logic   [IDX_W-1:0]         selHi;
  logic   [IDX_W-1:0]         selLo;
  logic   [IDX_W-1:0]         sel;
  ioReq_t                     selReq;

  // Unpack the flat request buses into one struct per lane and run the lane
  // eligibility check against the rotating pointer.
  for (genvar g = 0; g < IO_COUNT; g++) begin : gLane
    assign reqArr[g] = {we_in[g],
                        addr_in[g*ADDR_SIZE +: ADDR_SIZE],
                        wdata_in[g*WORD_SIZE +: WORD_SIZE]};

    io_rr_lane #(
      .IDX_W (IDX_W),
      .LANE  (g)
    ) uLane (
      .reqBit (req[g]),
      .ptr    (ptr),
      .hiReq  (hiReq[g])
    );
  end

  // Lowest set bit at or above ptr wins; if none, wrap to the lowest set bit
  // overall. Scanning downward lets the last hit be the lowest index.
  always_comb begin
    selHi = '0;
    selLo = '0;
    for (int i = IO_COUNT - 1; i >= 0; i--) begin
      if (hiReq[i]) selHi = IDX_W'(i);
      if (req[i])   selLo = IDX_W'(i);
    end
    sel    = (|hiReq) ? selHi : selLo;
    selReq = reqArr[sel];
  end

  // Transaction FSM; every output is registered and set on the transition
  // into the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      latCnt    <= '0;
      isWrite   <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            state     <= ISSUE;
            idx       <= sel;
            isWrite   <= selReq.we;
            gnt       <= IO_COUNT'(1) << sel;
            mem_en    <= 1'b1;
            mem_we    <= selReq.we;
            // mem_addr/mem_wdata double as the latched request and simply
            // hold until the next grant.
            mem_addr  <= selReq.addr;
            mem_wdata <= selReq.wdata;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (isWrite) begin
            state <= DONE;
            ack   <= gnt;
          end else begin
            state  <= WAIT;
            latCnt <= LAT_W'(MEM_LAT - 1);
          end
        end
        WAIT: begin
          if (latCnt == '0) begin
            rdata <= mem_rdata;
            state <= DONE;
            ack   <= gnt;
          end else begin
            latCnt <= latCnt - LAT_W'(1);
          end
        end
        DONE: begin
          ack   <= '0;
          gnt   <= '0;
          ptr   <= (idx == IDX_W'(IO_COUNT - 1)) ? '0 : idx + IDX_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_rr_arbiter.sv
// Directed bench for io_rr_arbiter (IO_COUNT=4, WORD_SIZE=16, MEM_LAT=2).
// Cycle 0 is the IDLE cycle whose closing edge samples req; outputs are
// sampled on the falling edge of each following cycle.
module tb_io_rr_arbiter;

  localparam int IO  = 4;
  localparam int WS  = 16;
  localparam int AS  = 16;
  localparam int LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IO-1:0]     req = '0;
  logic [IO-1:0]     we_in = '0;
  logic [IO*AS-1:0]  addr_in = '0;
  logic [IO*WS-1:0]  wdata_in = '0;
  logic [IO-1:0]     gnt;
  logic [IO-1:0]     ack;
  logic [WS-1:0]     rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AS-1:0]     mem_addr;
  logic [WS-1:0]     mem_wdata;
  logic [WS-1:0]     mem_rdata;

  int nChecks = 0;
  int nFails  = 0;

  io_rr_arbiter #(
    .IO_COUNT  (IO),
    .WORD_SIZE (WS),
    .ADDR_SIZE (AS),
    .MEM_LAT   (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we_in     (we_in),
    .addr_in   (addr_in),
    .wdata_in  (wdata_in),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read as 0x10nn, except 0x10 which reads
  // 0xBEEF; read data appears two cycles after the address is presented.
  logic [WS-1:0] mem [0:255];
  logic [255:0]  memValid = '0;
  logic [WS-1:0] rdP1 = '0;
  logic [WS-1:0] rdP2 = '0;

  function automatic logic [WS-1:0] memRead(input logic [7:0] a);
    if (memValid[a]) return mem[a];
    if (a == 8'h10)  return 16'hBEEF;
    return {8'h10, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[7:0]]      <= mem_wdata;
      memValid[mem_addr[7:0]] <= 1'b1;
    end
    rdP1 <= memRead(mem_addr[7:0]);
    rdP2 <= rdP1;
  end
  assign mem_rdata = rdP2;

  task automatic doReset();
    rst_n = 1'b0;
    req   = '0;
    we_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    nChecks++; if ({gnt, ack, mem_en, mem_we} !== 10'b0) begin nFails++; $display("FAIL reset_ctrl: got %b required 0", {gnt, ack, mem_en, mem_we}); end
    nChecks++; if (mem_addr !== 16'h0) begin nFails++; $display("FAIL reset_addr: got %h required 0000", mem_addr); end
    nChecks++; if (mem_wdata !== 16'h0) begin nFails++; $display("FAIL reset_wdata: got %h required 0000", mem_wdata); end
    nChecks++; if (rdata !== 16'h0) begin nFails++; $display("FAIL reset_rdata: got %h required 0000", rdata); end
    req = '0;
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++; if (gnt !== 4'b0) begin nFails++; $display("FAIL reset_idle_gnt: got %b required 0000", gnt); end
  endtask

  task automatic test_single_read();
    req = 4'b0001; we_in = 4'b0000; addr_in[0 +: AS] = 16'h0010;
    @(negedge clk); // cycle 1
    nChecks++; if ({mem_en, mem_we} !== 2'b10) begin nFails++; $display("FAIL rd_issue_en: got %b required 10", {mem_en, mem_we}); end
    nChecks++; if (mem_addr !== 16'h0010) begin nFails++; $display("FAIL rd_issue_addr: got %h required 0010", mem_addr); end
    nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL rd_issue_gnt: got %b required 0001", gnt); end
    // Late input changes must not disturb the in-flight read.
    req = 4'b0000; addr_in[0 +: AS] = 16'h0077;
    @(negedge clk); // cycle 2
    nChecks++; if (mem_en !== 1'b0) begin nFails++; $display("FAIL rd_wait_en: got %b required 0", mem_en); end
    nChecks++; if (mem_addr !== 16'h0010) begin nFails++; $display("FAIL rd_addr_hold: got %h required 0010", mem_addr); end
    nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL rd_wait_gnt: got %b required 0001", gnt); end
    @(negedge clk); // cycle 3
    nChecks++; if (ack !== 4'b0000) begin nFails++; $display("FAIL rd_early_ack: got %b required 0000", ack); end
    @(negedge clk); // cycle 4
    nChecks++; if (ack !== 4'b0001) begin nFails++; $display("FAIL rd_ack: got %b required 0001", ack); end
    nChecks++; if (rdata !== 16'hBEEF) begin nFails++; $display("FAIL rd_data: got %h required beef", rdata); end
    @(negedge clk); // cycle 5
    nChecks++; if ({gnt, ack} !== 8'b0) begin nFails++; $display("FAIL rd_after: got %b required 0", {gnt, ack}); end
  endtask

  // Runs with ptr=1 left by the read, so requester 2 is next in line.
  task automatic test_single_write();
    req = 4'b0100; we_in = 4'b0100;
    addr_in[2*AS +: AS] = 16'h0020; wdata_in[2*WS +: WS] = 16'h1234;
    @(negedge clk); // cycle 1
    nChecks++; if ({mem_en, mem_we} !== 2'b11) begin nFails++; $display("FAIL wr_issue_en: got %b required 11", {mem_en, mem_we}); end
    nChecks++; if (mem_addr !== 16'h0020) begin nFails++; $display("FAIL wr_addr: got %h required 0020", mem_addr); end
    nChecks++; if (mem_wdata !== 16'h1234) begin nFails++; $display("FAIL wr_wdata: got %h required 1234", mem_wdata); end
    nChecks++; if (gnt !== 4'b0100) begin nFails++; $display("FAIL wr_gnt: got %b required 0100", gnt); end
    req = '0; we_in = '0;
    @(negedge clk); // cycle 2
    nChecks++; if (ack !== 4'b0100) begin nFails++; $display("FAIL wr_ack: got %b required 0100", ack); end
    nChecks++; if ({mem_en, mem_we} !== 2'b00) begin nFails++; $display("FAIL wr_done_en: got %b required 00", {mem_en, mem_we}); end
    nChecks++; if (rdata !== 16'hBEEF) begin nFails++; $display("FAIL wr_rdata_hold: got %h required beef", rdata); end
    nChecks++; if (mem_wdata !== 16'h1234) begin nFails++; $display("FAIL wr_wdata_hold: got %h required 1234", mem_wdata); end
    @(negedge clk); // cycle 3
    nChecks++; if ({gnt, ack} !== 8'b0) begin nFails++; $display("FAIL wr_after: got %b required 0", {gnt, ack}); end
  endtask

  // ptr is now 3: requester 3 reads back what requester 2 wrote.
  task automatic test_readback();
    req = 4'b1000; we_in = '0; addr_in[3*AS +: AS] = 16'h0020;
    @(negedge clk);
    nChecks++; if (gnt !== 4'b1000) begin nFails++; $display("FAIL rb_gnt: got %b required 1000", gnt); end
    req = '0;
    @(negedge clk); @(negedge clk); @(negedge clk); // cycle 4
    nChecks++; if (ack !== 4'b1000) begin nFails++; $display("FAIL rb_ack: got %b required 1000", ack); end
    nChecks++; if (rdata !== 16'h1234) begin nFails++; $display("FAIL rb_data: got %h required 1234", rdata); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int got[$];
    int ackCyc[$];
    int expIdx[5] = '{0, 1, 2, 3, 0};
    logic [WS-1:0] expData[4] = '{16'hBEEF, 16'h1011, 16'h1012, 16'h1013};
    logic [IO-1:0] prevAck = '0;
    doReset();
    for (int i = 0; i < IO; i++) addr_in[i*AS +: AS] = AS'(16'h0010 + i);
    we_in = '0; req = 4'b1111;
    for (int cyc = 1; cyc <= 60 && got.size() < 5; cyc++) begin
      @(negedge clk);
      if (prevAck != '0) begin
        nChecks++; if (mem_en !== 1'b0) begin nFails++; $display("FAIL rr_gap: got mem_en %b after ack, required 0", mem_en); end
      end
      prevAck = ack;
      if (ack != '0) begin
        int who = -1;
        for (int i = 0; i < IO; i++) if (ack[i]) who = i;
        nChecks++; if (!$onehot(ack)) begin nFails++; $display("FAIL rr_onehot: got %b", ack); end
        nChecks++; if (who >= 0 && rdata !== expData[who]) begin nFails++; $display("FAIL rr_data: got %h required %h", rdata, expData[who]); end
        got.push_back(who);
        ackCyc.push_back(cyc);
        if (got.size() == 5) req = '0;
      end
    end
    nChecks++; if (got.size() != 5) begin nFails++; $display("FAIL rr_timeout: got %0d acks required 5", got.size()); end
    for (int n = 0; n < got.size(); n++) begin
      nChecks++; if (got[n] != expIdx[n]) begin nFails++; $display("FAIL rr_order[%0d]: got %0d required %0d", n, got[n], expIdx[n]); end
      nChecks++; if (ackCyc[n] != 4 + 5*n) begin nFails++; $display("FAIL rr_cycle[%0d]: got %0d required %0d", n, ackCyc[n], 4 + 5*n); end
    end
    @(negedge clk);
  endtask

  task automatic test_skip_idle();
    int got[$];
    int ackCyc[$];
    int expIdx[3] = '{3, 0, 3};
    doReset();
    // One write from requester 0 moves ptr to 1.
    req = 4'b0001; we_in = 4'b0001; addr_in[0 +: AS] = 16'h0040; wdata_in[0 +: WS] = 16'h5555;
    @(negedge clk); req = '0;
    @(negedge clk);
    nChecks++; if (ack !== 4'b0001) begin nFails++; $display("FAIL skip_setup_ack: got %b required 0001", ack); end
    @(negedge clk);
    req = 4'b1001; we_in = 4'b1001; addr_in[3*AS +: AS] = 16'h0041;
    for (int cyc = 1; cyc <= 40 && got.size() < 3; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin
        int who = -1;
        for (int i = 0; i < IO; i++) if (ack[i]) who = i;
        got.push_back(who);
        ackCyc.push_back(cyc);
        if (got.size() == 3) req = '0;
      end
    end
    nChecks++; if (got.size() != 3) begin nFails++; $display("FAIL skip_timeout: got %0d acks required 3", got.size()); end
    for (int n = 0; n < got.size(); n++) begin
      nChecks++; if (got[n] != expIdx[n]) begin nFails++; $display("FAIL skip_order[%0d]: got %0d required %0d", n, got[n], expIdx[n]); end
      nChecks++; if (ackCyc[n] != 2 + 3*n) begin nFails++; $display("FAIL skip_cycle[%0d]: got %0d required %0d", n, ackCyc[n], 2 + 3*n); end
    end
    we_in = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    int firstCyc = -1;
    logic [IO-1:0] firstAck = '0;
    doReset();
    req = 4'b0001; we_in = '0; addr_in[0 +: AS] = 16'h0010;
    @(negedge clk); // cycle 1
    nChecks++; if (mem_en !== 1'b1) begin nFails++; $display("FAIL mid_issue: got %b required 1", mem_en); end
    @(negedge clk); // cycle 2, WAIT
    nChecks++; if (gnt !== 4'b0001) begin nFails++; $display("FAIL mid_wait_gnt: got %b required 0001", gnt); end
    rst_n = 1'b0; req = 4'b0010; addr_in[1*AS +: AS] = 16'h0011;
    #1;
    nChecks++; if ({gnt, ack, mem_en, mem_we} !== 10'b0) begin nFails++; $display("FAIL mid_async: got %b required 0", {gnt, ack, mem_en, mem_we}); end
    nChecks++; if (mem_addr !== 16'h0) begin nFails++; $display("FAIL mid_addr: got %h required 0000", mem_addr); end
    @(negedge clk); @(negedge clk);
    nChecks++; if (ack !== 4'b0) begin nFails++; $display("FAIL mid_no_ack: got %b required 0000", ack); end
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 12 && firstCyc < 0; cyc++) begin
      @(negedge clk);
      if (ack != '0) begin firstCyc = cyc; firstAck = ack; end
    end
    nChecks++; if (firstAck !== 4'b0010) begin nFails++; $display("FAIL mid_first_ack: got %b required 0010", firstAck); end
    nChecks++; if (firstCyc != 4) begin nFails++; $display("FAIL mid_latency: got %0d required 4", firstCyc); end
    nChecks++; if (rdata !== 16'h1011) begin nFails++; $display("FAIL mid_rdata: got %h required 1011", rdata); end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_readback();
    test_round_robin();
    test_skip_idle();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
